// File: rtl/cop_issue_driver_if.sv
// CPU<->COP issue bus: command queue input, COP handshakes,
// retire record and status outputs.
interface cop_issue_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_insn_enc;
    logic [31:0] cmd_rs1;
    logic        cop_in_valid;
    logic        cop_in_ready;
    logic [31:0] cop_insn_enc;
    logic [31:0] cop_rs1;
    logic        cop_out_valid;
    logic        cop_out_ack;
    logic [2:0]  cop_result;
    logic        cop_rd_wen;
    logic [4:0]  cop_rd_addr;
    logic [31:0] cop_rd_data;
    logic        ret_valid;
    logic [2:0]  ret_result;
    logic        ret_rd_wen;
    logic [4:0]  ret_rd_addr;
    logic [31:0] ret_rd_data;
    logic [10:0] tx_issued;
    logic [10:0] tx_retired;
    logic        busy;
    logic        err_timeout;
    logic        err_spurious;

    modport master (
        input  cmd_valid, cmd_insn_enc, cmd_rs1,
        input  cop_in_ready, cop_out_valid, cop_result,
        input  cop_rd_wen, cop_rd_addr, cop_rd_data,
        output cmd_ready, cop_in_valid, cop_insn_enc, cop_rs1,
        output cop_out_ack, ret_valid, ret_result, ret_rd_wen,
        output ret_rd_addr, ret_rd_data, tx_issued, tx_retired,
        output busy, err_timeout, err_spurious
    );

    modport slave (
        output cmd_valid, cmd_insn_enc, cmd_rs1,
        output cop_in_ready, cop_out_valid, cop_result,
        output cop_rd_wen, cop_rd_addr, cop_rd_data,
        input  cmd_ready, cop_in_valid, cop_insn_enc, cop_rs1,
        input  cop_out_ack, ret_valid, ret_result, ret_rd_wen,
        input  ret_rd_addr, ret_rd_data, tx_issued, tx_retired,
        input  busy, err_timeout, err_spurious
    );
endinterface

// File: rtl/cop_issue_driver.sv
// CPU-side coprocessor initiator: queues commands, issues one at a
// time, retires or times out the response, flags spurious results.
module cop_issue_driver #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input logic                 g_clk,
    input logic                 g_resetn,
    cop_issue_driver_if.master  bus
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_q, rd_q;
    logic [63:0] mem_q [CMD_DEPTH];
    logic [15:0] wait_q, wait_d;
    logic [31:0] enc_q, enc_d, rs1_q, rs1_d;
    logic        ret_valid_q;
    logic [2:0]  ret_result_q;
    logic        ret_wen_q;
    logic [4:0]  ret_addr_q;
    logic [31:0] ret_data_q;
    logic [10:0] iss_q, rtd_q;
    logic        tmo_q, spur_q;

    logic full, empty, push, pop;
    logic issue, retire, tmo, spur;

    // Extra pointer bit distinguishes full from empty
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push  = bus.cmd_valid && !full;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        enc_d   = enc_q;
        rs1_d   = rs1_q;
        pop     = 1'b0;
        issue   = 1'b0;
        retire  = 1'b0;
        tmo     = 1'b0;
        spur    = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): begin
                spur = bus.cop_out_valid;
                if (!empty) begin
                    pop     = 1'b1;
                    enc_d   = mem_q[rd_q[AW-1:0]][63:32];
                    rs1_d   = mem_q[rd_q[AW-1:0]][31:0];
                    state_d = ISSUE;
                end
            end
            (state_q == ISSUE): begin
                if (bus.cop_in_ready) begin
                    issue = 1'b1;
                    if (bus.cop_out_valid) begin
                        retire  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wait_d  = '0;
                        state_d = WAIT;
                    end
                end else begin
                    spur = bus.cop_out_valid;
                end
            end
            (state_q == WAIT): begin
                if (bus.cop_out_valid) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {bus.cmd_insn_enc, bus.cmd_rs1};
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q      <= IDLE;
            wr_q         <= '0;
            rd_q         <= '0;
            wait_q       <= '0;
            enc_q        <= '0;
            rs1_q        <= '0;
            ret_valid_q  <= 1'b0;
            ret_result_q <= '0;
            ret_wen_q    <= 1'b0;
            ret_addr_q   <= '0;
            ret_data_q   <= '0;
            iss_q        <= '0;
            rtd_q        <= '0;
            tmo_q        <= 1'b0;
            spur_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            enc_q       <= enc_d;
            rs1_q       <= rs1_d;
            ret_valid_q <= retire;
            if (push)  wr_q  <= wr_q + 1'b1;
            if (pop)   rd_q  <= rd_q + 1'b1;
            if (issue) iss_q <= iss_q + 11'd1;
            if (retire) begin
                rtd_q        <= rtd_q + 11'd1;
                ret_result_q <= bus.cop_result;
                ret_wen_q    <= bus.cop_rd_wen;
                ret_addr_q   <= bus.cop_rd_addr;
                ret_data_q   <= bus.cop_rd_data;
            end
            if (tmo)  tmo_q  <= 1'b1;
            if (spur) spur_q <= 1'b1;
        end
    end

    assign bus.cmd_ready    = !full;
    assign bus.cop_in_valid = (state_q == ISSUE);
    assign bus.cop_insn_enc = enc_q;
    assign bus.cop_rs1      = rs1_q;
    assign bus.cop_out_ack  = bus.cop_out_valid;
    assign bus.ret_valid    = ret_valid_q;
    assign bus.ret_result   = ret_result_q;
    assign bus.ret_rd_wen   = ret_wen_q;
    assign bus.ret_rd_addr  = ret_addr_q;
    assign bus.ret_rd_data  = ret_data_q;
    assign bus.tx_issued    = iss_q;
    assign bus.tx_retired   = rtd_q;
    assign bus.busy         = !empty || (state_q != IDLE);
    assign bus.err_timeout  = tmo_q;
    assign bus.err_spurious = spur_q;
endmodule

// File: tb/tb_cop_issue_driver.sv
// Directed bench for cop_issue_driver: issue, back-pressure,
// same-cycle retire, FIFO full, timeout, spurious response.
module tb_cop_issue_driver;
    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    cop_issue_driver_if bus();

    cop_issue_driver #(.CMD_DEPTH(4), .TIMEOUT(8)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] enc, input logic [31:0] rs1);
        bus.cmd_valid    = 1'b1;
        bus.cmd_insn_enc = enc;
        bus.cmd_rs1      = rs1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic respond(input logic [2:0] res, input logic wen,
                           input logic [4:0] addr, input logic [31:0] data);
        bus.cop_out_valid = 1'b1;
        bus.cop_result    = res;
        bus.cop_rd_wen    = wen;
        bus.cop_rd_addr   = addr;
        bus.cop_rd_data   = data;
        tick();
        bus.cop_out_valid = 1'b0;
    endtask

    task automatic do_reset();
        g_resetn = 1'b0;
        tick();
        tick();
        g_resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got stuck exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_enc [5];
        bit found;
        bus.cmd_valid     = 1'b0;
        bus.cmd_insn_enc  = '0;
        bus.cmd_rs1       = '0;
        bus.cop_in_ready  = 1'b0;
        bus.cop_out_valid = 1'b0;
        bus.cop_result    = '0;
        bus.cop_rd_wen    = 1'b0;
        bus.cop_rd_addr   = '0;
        bus.cop_rd_data   = '0;
        do_reset();

        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_in_valid", bus.cop_in_valid, 0);
        chk("rst_enc", bus.cop_insn_enc, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx", {bus.tx_issued, bus.tx_retired}, 0);
        chk("rst_err", {bus.err_timeout, bus.err_spurious}, 0);
        chk("rst_ret", {bus.ret_valid, bus.ret_rd_data}, 0);

        // single instruction
        bus.cop_in_ready = 1'b1;
        push(32'h0000_100B, 32'hDEAD_BEEF);
        chk("t1_busy", bus.busy, 1);
        chk("t1_no_valid_yet", bus.cop_in_valid, 0);
        tick();
        chk("t1_in_valid", bus.cop_in_valid, 1);
        chk("t1_enc", bus.cop_insn_enc, 64'h0000_100B);
        chk("t1_rs1", bus.cop_rs1, 64'hDEAD_BEEF);
        tick();
        chk("t1_issued", bus.tx_issued, 1);
        chk("t1_wait_valid", bus.cop_in_valid, 0);
        tick();
        tick();
        bus.cop_out_valid = 1'b1;
        #1;
        chk("t1_ack", bus.cop_out_ack, 1);
        respond(3'd0, 1'b1, 5'd5, 32'h1234_5678);
        chk("t1_ret_valid", bus.ret_valid, 1);
        chk("t1_ret_rec", {bus.ret_result, bus.ret_rd_wen,
            bus.ret_rd_addr, bus.ret_rd_data}, {3'd0, 1'b1, 5'd5, 32'h1234_5678});
        chk("t1_tx", {bus.tx_issued, bus.tx_retired}, {11'd1, 11'd1});
        tick();
        chk("t1_ret_pulse", bus.ret_valid, 0);
        chk("t1_ret_hold", bus.ret_rd_data, 64'h1234_5678);

        // back-pressure for 6 cycles
        bus.cop_in_ready = 1'b0;
        push(32'h2000_200B, 32'h1111_2222);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t2_hold_valid", bus.cop_in_valid, 1);
            chk("t2_hold_data", {bus.cop_insn_enc, bus.cop_rs1},
                {32'h2000_200B, 32'h1111_2222});
            chk("t2_no_issue", bus.tx_issued, 1);
            tick();
        end
        bus.cop_in_ready = 1'b1;
        tick();
        bus.cop_in_ready = 1'b0;
        chk("t2_issued", bus.tx_issued, 2);
        respond(3'd3, 1'b0, 5'd7, 32'h0000_CAFE);
        chk("t2_ret_rec", {bus.ret_result, bus.ret_rd_wen,
            bus.ret_rd_addr, bus.ret_rd_data}, {3'd3, 1'b0, 5'd7, 32'h0000_CAFE});
        chk("t2_retired", bus.tx_retired, 2);

        // same-cycle issue and response
        push(32'h3000_300B, 32'h3);
        push(32'h4000_400B, 32'h4);
        chk("t3_a_issue", bus.cop_insn_enc, 64'h3000_300B);
        bus.cop_in_ready  = 1'b1;
        bus.cop_out_valid = 1'b1;
        bus.cop_result    = 3'd1;
        #1;
        chk("t3_ack", bus.cop_out_ack, 1);
        tick();
        bus.cop_out_valid = 1'b0;
        chk("t3_idle_gap", bus.cop_in_valid, 0);
        chk("t3_tx", {bus.tx_issued, bus.tx_retired}, {11'd3, 11'd3});
        chk("t3_ret", {bus.ret_valid, bus.ret_result}, {1'b1, 3'd1});
        tick();
        chk("t3_b_issue", {bus.cop_in_valid, bus.cop_insn_enc},
            {1'b1, 32'h4000_400B});
        tick();
        bus.cop_in_ready = 1'b0;
        respond(3'd0, 1'b0, 5'd0, 32'h0);
        chk("t3_tx_b", {bus.tx_issued, bus.tx_retired}, {11'd4, 11'd4});

        // FIFO full while COP stalls
        for (int i = 0; i < 5; i++) begin
            exp_enc[i] = 32'h5000_0000 + 32'(i);
            chk("t4_ready", bus.cmd_ready, 1);
            push(exp_enc[i], 32'(i));
        end
        chk("t4_full", bus.cmd_ready, 0);
        push(32'hBAD0_BAD0, 32'h0);
        chk("t4_still_full", bus.cmd_ready, 0);
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                if (bus.cop_in_valid) found = 1'b1;
                else tick();
            end
            chk("t4_issue_seen", found, 1);
            chk("t4_order", bus.cop_insn_enc, exp_enc[k]);
            bus.cop_in_ready = 1'b1;
            tick();
            bus.cop_in_ready = 1'b0;
            respond(3'd2, 1'b1, 5'(k), 32'(k));
        end
        chk("t4_tx", {bus.tx_issued, bus.tx_retired}, {11'd9, 11'd9});
        chk("t4_drained", bus.busy, 0);

        // timeout after exactly 8 WAIT cycles
        bus.cop_in_ready = 1'b1;
        push(32'h6000_600B, 32'h6);
        tick();
        tick();
        chk("t5_issued", bus.tx_issued, 10);
        for (int i = 0; i < 7; i++) tick();
        chk("t5_not_yet", bus.err_timeout, 0);
        tick();
        chk("t5_timeout", bus.err_timeout, 1);
        chk("t5_retired", bus.tx_retired, 9);
        push(32'h7000_700B, 32'h7);
        tick();
        chk("t5_next_issue", {bus.cop_in_valid, bus.cop_insn_enc},
            {1'b1, 32'h7000_700B});
        tick();
        respond(3'd0, 1'b0, 5'd1, 32'h1);
        chk("t5_tx", {bus.tx_issued, bus.tx_retired}, {11'd11, 11'd10});

        // reset mid-operation
        bus.cop_in_ready = 1'b0;
        push(32'h8000_800B, 32'h8);
        push(32'h9000_900B, 32'h9);
        do_reset();
        chk("t6_rst_flags", {bus.err_timeout, bus.err_spurious}, 0);
        chk("t6_rst_state", {bus.cop_in_valid, bus.busy, bus.cmd_ready},
            {1'b0, 1'b0, 1'b1});
        chk("t6_rst_tx", {bus.tx_issued, bus.tx_retired}, 0);
        chk("t6_rst_ret", bus.ret_rd_data, 0);
        tick();
        chk("t6_flushed", bus.cop_in_valid, 0);

        // spurious response while IDLE
        bus.cop_out_valid = 1'b1;
        #1;
        chk("t7_ack", bus.cop_out_ack, 1);
        tick();
        bus.cop_out_valid = 1'b0;
        chk("t7_spurious", bus.err_spurious, 1);
        chk("t7_no_ret", bus.ret_valid, 0);
        chk("t7_tx", {bus.tx_issued, bus.tx_retired}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
